// File: rtl/fractcam_rule_writer.sv
// Rule writer for the FRACTCAM search array: expands one ternary rule (key + care-mask)
// into 32 parallel SRL32 shift-in streams, address 31 first down to address 0.
module fractcam_rule_writer #(
  parameter int KEY_W   = 160,
  parameter int NUM_SRL = KEY_W / 5,
  parameter int ADDR_W  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rule_valid,
  output logic               rule_ready,
  input  logic [KEY_W-1:0]   rule_key,
  input  logic [KEY_W-1:0]   rule_mask,
  input  logic               rule_del,
  input  logic [ADDR_W-1:0]  rule_addr,
  output logic               srl_ce,
  output logic [NUM_SRL-1:0] srl_din,
  output logic [ADDR_W-1:0]  srl_sel,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [4:0]         cnt, cnt_next;
  logic [KEY_W-1:0]   key_q, key_next;
  logic [KEY_W-1:0]   mask_q, mask_next;
  logic               del_q, del_next;
  logic [ADDR_W-1:0]  sel_next;
  logic               ce_next, done_next, busy_next, ready_next;
  logic [NUM_SRL-1:0] din_next;

  // A slice matches SRL address a when every cared-about bit agrees with the key.
  function automatic logic slice_hit(input logic [4:0] a, input logic [4:0] v,
                                     input logic [4:0] m, input logic del);
    return !del && (((a ^ v) & m) == 5'b00000);
  endfunction

  // State, counter, latched rule and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd31;
      key_q      <= {KEY_W{1'b0}};
      mask_q     <= {KEY_W{1'b0}};
      del_q      <= 1'b0;
      srl_sel    <= {ADDR_W{1'b0}};
      srl_ce     <= 1'b0;
      srl_din    <= {NUM_SRL{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      rule_ready <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      key_q      <= key_next;
      mask_q     <= mask_next;
      del_q      <= del_next;
      srl_sel    <= sel_next;
      srl_ce     <= ce_next;
      srl_din    <= din_next;
      busy       <= busy_next;
      done       <= done_next;
      rule_ready <= ready_next;
    end
  end

  // Next-state logic; the rule is captured on the accepting edge
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    key_next   = key_q;
    mask_next  = mask_q;
    del_next   = del_q;
    sel_next   = srl_sel;
    case (state)
      IDLE: begin
        if (rule_valid) begin
          state_next = SHIFT;
          cnt_next   = 5'd31;
          key_next   = rule_key;
          mask_next  = rule_mask;
          del_next   = rule_del;
          sel_next   = rule_addr;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        // cnt wraps to 31 on the last shift, which is also its idle value
        cnt_next = cnt - 5'd1;
        if (cnt == 5'd0) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, so every output leaves a flop
  always_comb begin
    ce_next    = (state_next == SHIFT);
    done_next  = (state_next == DONE);
    busy_next  = (state_next != IDLE);
    ready_next = (state_next == IDLE);
    din_next   = {NUM_SRL{1'b0}};
    if (ce_next) begin
      for (int i = 0; i < NUM_SRL; i++) begin
        din_next[i] = slice_hit(cnt_next, key_next[5*i +: 5], mask_next[5*i +: 5], del_next);
      end
    end else begin
      din_next = {NUM_SRL{1'b0}};
    end
  end

endmodule

// File: tb/tb_fractcam_rule_writer.sv
// Scoreboard bench for fractcam_rule_writer: expected shift words are queued when a rule
// is driven and popped on every cycle the DUT shifts.
module tb_fractcam_rule_writer;

  localparam int KEY_W   = 160;
  localparam int NUM_SRL = 32;
  localparam int ADDR_W  = 7;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               rule_valid = 1'b0;
  logic               rule_ready;
  logic [KEY_W-1:0]   rule_key = '0;
  logic [KEY_W-1:0]   rule_mask = '0;
  logic               rule_del = 1'b0;
  logic [ADDR_W-1:0]  rule_addr = '0;
  logic               srl_ce;
  logic [NUM_SRL-1:0] srl_din;
  logic [ADDR_W-1:0]  srl_sel;
  logic               busy;
  logic               done;

  int tests_run = 0;
  int tests_failed = 0;
  int run_len = 0;
  int cyc = 0;
  logic [NUM_SRL-1:0] din_q[$];
  logic [ADDR_W-1:0]  sel_q[$];
  int                 acc_q[$];

  fractcam_rule_writer #(.KEY_W(KEY_W), .NUM_SRL(NUM_SRL), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rule_valid(rule_valid), .rule_ready(rule_ready),
    .rule_key(rule_key), .rule_mask(rule_mask), .rule_del(rule_del), .rule_addr(rule_addr),
    .srl_ce(srl_ce), .srl_din(srl_din), .srl_sel(srl_sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // mode 0: reference formula, 1: all ones, 2: all zeros
  task automatic push_expect(input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask,
                             input logic del, input logic [ADDR_W-1:0] addr, input int mode);
    logic [4:0] a, v, m;
    logic [NUM_SRL-1:0] w;
    for (int k = 0; k < 32; k++) begin
      a = 5'(31 - k);
      w = '0;
      for (int i = 0; i < NUM_SRL; i++) begin
        v = key[5*i +: 5];
        m = mask[5*i +: 5];
        w[i] = !del && (((a ^ v) & m) == 5'b0);
      end
      if (mode == 1) w = 32'hFFFF_FFFF;
      if (mode == 2) w = 32'h0000_0000;
      din_q.push_back(w);
      sel_q.push_back(addr);
    end
  endtask

  task automatic send_rule(input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] mask,
                           input logic del, input logic [ADDR_W-1:0] addr, input int mode);
    int n;
    n = 0;
    @(negedge clk);
    while (!rule_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_value("ready_timeout", 64'd0, 64'd1);
    rule_key = key; rule_mask = mask; rule_del = del; rule_addr = addr;
    rule_valid = 1'b1;
    push_expect(key, mask, del, addr, mode);
    @(posedge clk);
    #1;
    // scramble inputs to prove the rule was latched
    rule_valid = 1'b0;
    rule_key   = {5{$urandom()}};
    rule_mask  = {5{$urandom()}};
    rule_del   = 1'($urandom_range(0, 1));
    rule_addr  = 7'($urandom());
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    if (!done) check_value("done_timeout", 64'd0, 64'd1);
  endtask

  always @(posedge clk) begin
    if (!reset && rule_valid && rule_ready) acc_q.push_back(cyc);
    cyc++;
  end

  // Scoreboard/monitor
  always @(negedge clk) begin
    if (reset) begin
      run_len = 0;
    end else if (srl_ce) begin
      run_len++;
      if (din_q.size() == 0) begin
        check_value("ce_extra", 64'd1, 64'd0);
      end else begin
        check_value("srl_din", srl_din, din_q.pop_front());
        check_value("srl_sel", srl_sel, sel_q.pop_front());
      end
      check_value("ready_in_shift", rule_ready, 64'd0);
      check_value("busy_in_shift", busy, 64'd1);
    end else begin
      check_value("din_zero_no_ce", srl_din, 64'd0);
      if (done) begin
        check_value("shift_len", run_len, 64'd32);
        check_value("ready_in_done", rule_ready, 64'd0);
        check_value("busy_in_done", busy, 64'd1);
        run_len = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KEY_W-1:0] ones, m2, k17;
    ones = {KEY_W{1'b1}};
    k17  = '0;
    k17[4:0] = 5'd17;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_ready", rule_ready, 64'd1);
    check_value("rst_ce", srl_ce, 64'd0);
    check_value("rst_din", srl_din, 64'd0);
    check_value("rst_sel", srl_sel, 64'd0);
    check_value("rst_busy", busy, 64'd0);
    check_value("rst_done", done, 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_value("idle_ready", rule_ready, 64'd1);
      check_value("idle_ce", srl_ce, 64'd0);
      check_value("idle_busy", busy, 64'd0);
      check_value("idle_done", done, 64'd0);
    end

    // exact single value, full care
    send_rule(k17, ones, 1'b0, 7'd0, 0);
    wait_done();

    // low bit of slice 0 is don't-care -> addresses 16 and 17 hit
    m2 = ones;
    m2[4:0] = 5'b11110;
    send_rule(k17, m2, 1'b0, 7'd2, 0);
    wait_done();

    send_rule({5{$urandom()}}, '0, 1'b0, 7'd9, 1);
    wait_done();

    send_rule({5{$urandom()}}, {5{$urandom()}}, 1'b1, 7'd127, 2);
    wait_done();

    for (int r = 0; r < 3; r++) begin
      send_rule({5{$urandom()}}, {5{$urandom()}}, 1'b0, 7'($urandom()), 0);
      wait_done();
    end

    // back-to-back with rule_valid held high
    @(negedge clk);
    acc_q.delete();
    rule_key = {5{$urandom()}}; rule_mask = {5{$urandom()}}; rule_del = 1'b0; rule_addr = 7'd44;
    push_expect(rule_key, rule_mask, 1'b0, 7'd44, 0);
    push_expect(rule_key, rule_mask, 1'b0, 7'd44, 0);
    rule_valid = 1'b1;
    wait_done();
    @(posedge clk);
    @(posedge clk);
    #1;
    rule_valid = 1'b0;
    wait_done();
    check_value("b2b_accepts", acc_q.size(), 64'd2);
    if (acc_q.size() == 2) check_value("b2b_spacing", acc_q[1] - acc_q[0], 64'd34);

    // reset in the middle of a shift
    send_rule({5{$urandom()}}, {5{$urandom()}}, 1'b0, 7'd5, 0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    din_q.delete();
    sel_q.delete();
    check_value("mid_rst_ce", srl_ce, 64'd0);
    check_value("mid_rst_done", done, 64'd0);
    check_value("mid_rst_ready", rule_ready, 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_value("post_rst_no_done", done, 64'd0);
    end
    send_rule({5{$urandom()}}, {5{$urandom()}}, 1'b0, 7'd6, 0);
    wait_done();

    repeat (3) @(negedge clk);
    check_value("queue_empty", din_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
